// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - scan states and active-high 7-segment patterns (gfedcba)
package seg_display_pkg;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-high 7-segment pattern
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_scan.sv
// rtl/count_display_scan.sv - two-digit multiplexed 7-segment scan of a 0..15 count
// Optional leading-zero blanking of the tens digit: COUNT_DISPLAY_ZERO_BLANK_EN
module count_display_scan
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_INV  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]      AN_INV   = ACTIVE_LOW ? 2'b11 : 2'b00;

    if (REFRESH_DIV < 2) begin : g_cfg_err
        $error("count_display_scan: REFRESH_DIV must be at least 2");
    end

    logic [DIV_W-1:0] div_cnt;
    scan_state_e      state;
    scan_state_e      state_nxt;
    logic [3:0]       value_q;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [6:0]       ones_pat;
    logic [6:0]       tens_pat;
    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;
    logic             div_wrap;
    logic             boundary;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign boundary = div_wrap && (state == S_TENS);

    assign tens = (value_q >= 4'd10) ? 4'd1 : 4'd0;
    assign ones = (value_q >= 4'd10) ? (value_q - 4'd10) : value_q;

    seg7_decode u_ones_dec (.digit(ones), .pattern(ones_pat));
    seg7_decode u_tens_dec (.digit(tens), .pattern(tens_pat));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ONES;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (div_wrap) begin
            case (state)
                S_ONES:  state_nxt = S_TENS;
                S_TENS:  state_nxt = S_ONES;
                default: state_nxt = S_ONES;
            endcase
        end
    end

    // Active-high digit drive for the current state; polarity is applied at the register.
    always_comb begin
        seg_nxt = ones_pat;
        an_nxt  = 2'b01;
        if (state == S_TENS) begin
            seg_nxt = tens_pat;
            an_nxt  = 2'b10;
`ifdef COUNT_DISPLAY_ZERO_BLANK_EN
            if (tens == 4'd0) begin
                seg_nxt = SEG_BLANK;
                an_nxt  = 2'b00;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            value_q    <= 4'd0;
            frame_tick <= 1'b0;
            seg        <= SEG_INV;
            an         <= AN_INV;
        end else begin
            div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
            frame_tick <= boundary;
            if (boundary && !hold) begin
                value_q <= count_in;
            end
            seg <= seg_nxt ^ SEG_INV;
            an  <= an_nxt ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_count_display_scan.sv
// tb/tb_count_display_scan.sv - self-checking bench for count_display_scan
module tb_count_display_scan;

    localparam int R     = 4;
    localparam int FRAME = 2 * R;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       hold;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int val    = 0;

    always #5 clk = ~clk;

    count_display_scan #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .hold       (hold),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k counts non-reset edges since reset; outputs show the scan position one edge earlier.
    task automatic tick(input logic r, input logic [3:0] c, input logic h);
        logic [6:0] e_seg;
        logic [1:0] e_an;
        logic       e_ft;
        int         tens;
        int         ones;
        reset    = r;
        count_in = c;
        hold     = h;
        @(posedge clk);
        if (r) begin
            k     = 0;
            val   = 0;
            e_seg = 7'h7F;
            e_an  = 2'b11;
            e_ft  = 1'b0;
        end else begin
            k++;
            tens = val / 10;
            ones = val % 10;
            if ((((k - 1) / R) % 2) == 1) begin
                e_an  = 2'b10;
                e_seg = PAT[tens];
`ifdef COUNT_DISPLAY_ZERO_BLANK_EN
                if (tens == 0) begin
                    e_an  = 2'b00;
                    e_seg = 7'h00;
                end
`endif
            end else begin
                e_an  = 2'b01;
                e_seg = PAT[ones];
            end
            e_seg = ~e_seg;
            e_an  = ~e_an;
            e_ft  = ((k % FRAME) == 0);
            if (e_ft && !h) val = int'(c);
        end
        #1;
        check("seg", seg, e_seg);
        check("an", {5'b0, an}, {5'b0, e_an});
        check("frame_tick", {6'b0, frame_tick}, {6'b0, e_ft});
        check("an_onehot", {6'b0, ($countones(~an) <= 1)}, 7'd1);
    endtask

    initial begin
        reset    = 1'b1;
        count_in = 4'd7;
        hold     = 1'b0;

        repeat (5) tick(1'b1, 4'd7, 1'b0);

        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 4'd13, 1'b0);
            if (i == 1)  check("s2_first_ones_0", seg, 7'h40);
            if (i == 8)  check("s2_first_tick", {6'b0, frame_tick}, 7'd1);
            if (i == 9)  check("s2_ones_3", seg, 7'h30);
            if (i == 13) check("s2_tens_1", seg, 7'h79);
        end

        repeat (24) tick(1'b0, 4'd5, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 4'd5, 1'b0);
            if (i == 9) check("s3_ones_5", seg, 7'h12);
        end

        repeat (8) tick(1'b0, 4'd9, 1'b0);
        for (int i = 1; i <= 8; i++) tick(1'b0, (i <= 3) ? 4'd9 : 4'd10, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 4'd10, 1'b0);
            if (i == 1) check("s4_ones_0", seg, 7'h40);
            if (i == 5) check("s4_tens_1", seg, 7'h79);
        end

        repeat (5) tick(1'b0, 4'd3, 1'b0);
        tick(1'b1, 4'd3, 1'b0);
        check("s5_reset_seg", seg, 7'h7F);
        repeat (16) tick(1'b0, 4'd3, 1'b0);

        repeat (8) tick(1'b0, 4'd14, 1'b0);
        repeat (8) tick(1'b0, 4'd15, 1'b0);
        repeat (8) tick(1'b0, 4'd0, 1'b0);
        repeat (8) tick(1'b0, 4'd1, 1'b0);
        repeat (8) tick(1'b0, 4'd1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
